pipe_stage_reg: RTL

Parametrised inter-stage pipeline register. It replaces the fixed per-field ID/EX-style bridges with one generic stage carrying a control bundle and a data bundle under a valid/ready handshake. A flush turns held entries into bubbles: control is cleared and valid dropped, while the data bundle (PC/IR and similar trace fields) is still captured. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and provides stall via back-pressure, an optional skid entry, and a saturating flush counter.

---
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with control/data bundles, flush-to-bubble and a saturating flush counter.
// Define PIPE_SKID_EN to add a skid entry, which gives a registered in_ready and full throughput under back-pressure.
module pipe_stage_reg #(
    parameter int unsigned       CTRL_W   = 32,
    parameter int unsigned       DATA_W   = 96,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int unsigned       CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                m_valid;
    logic                s_valid;
    logic                in_fire;
    logic                out_fire;
    logic                flush_hit;

    assign m_valid = (state_q != EMPTY);

`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;

    // in_ready depends only on state, so there is no path from out_ready
    assign s_valid  = (state_q == SKID);
    assign in_ready = ~s_valid;
`else
    assign s_valid  = 1'b0;
    assign in_ready = ~m_valid | out_ready;
`endif

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;
    assign flush_hit = flush & (m_valid | s_valid | in_valid);

    assign cnt_d = (flush_hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
`ifdef PIPE_SKID_EN
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
`endif
        if (flush) begin
            // bubble: control cleared, data still captured for trace
            state_d  = EMPTY;
            m_ctrl_d = CTRL_RST;
            if (in_valid) begin
                m_data_d = in_data;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                        state_d  = FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_ready) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
`ifdef PIPE_SKID_EN
                    end else if (in_fire) begin
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                        state_d  = SKID;
`endif
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                SKID: begin
                    if (out_ready) begin
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        state_d  = FULL;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            m_ctrl_q <= CTRL_RST;
            m_data_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ctrl_q <= '0;
            s_data_q <= '0;
        end else begin
            s_ctrl_q <= s_ctrl_d;
            s_data_q <= s_data_d;
        end
    end
`endif

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign flush_cnt = cnt_q;

endmodule
